// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the fetch and load/store ports shared access to the
// single-ported Memory; one transaction every three clocks, with console input acknowledge.
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] IN_ADDR = 16'h0100
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              KernelMode,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic              IfGnt,
  output logic              IfValid,
  output logic [DATA_W-1:0] IfData,
  output logic              IfFault,
  input  logic              DReq,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic              DWrite,
  input  logic [DATA_W-1:0] DWData,
  output logic              DGnt,
  output logic              DValid,
  output logic [DATA_W-1:0] DRData,
  output logic              DFault,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWriteFlag,
  output logic              MemKernelFlag,
  output logic              MemInputRst,
  input  logic [DATA_W-1:0] MemReadData,
  input  logic              MemAccInv,
  input  logic              MemInputRecv
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state;
  logic   lastGntD;
  logic   winD;
  logic   latWrite;
  logic   pickD;

  // On a tie the port that did not win last time gets the memory.
  assign pickD = DReq & (~IfReq | ~lastGntD);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      lastGntD      <= 1'b1;
      winD          <= 1'b0;
      latWrite      <= 1'b0;
      IfGnt         <= 1'b0;
      IfValid       <= 1'b0;
      IfData        <= '0;
      IfFault       <= 1'b0;
      DGnt          <= 1'b0;
      DValid        <= 1'b0;
      DRData        <= '0;
      DFault        <= 1'b0;
      MemAddr       <= '0;
      MemWriteData  <= '0;
      MemWriteFlag  <= 1'b0;
      MemKernelFlag <= 1'b0;
      MemInputRst   <= 1'b0;
    end else begin
      IfGnt        <= 1'b0;
      DGnt         <= 1'b0;
      IfValid      <= 1'b0;
      DValid       <= 1'b0;
      MemInputRst  <= 1'b0;
      MemWriteFlag <= 1'b0;
      case (state)
        IDLE: begin
          if (IfReq || DReq) begin
            winD          <= pickD;
            lastGntD      <= pickD;
            IfGnt         <= ~pickD;
            DGnt          <= pickD;
            MemAddr       <= pickD ? DAddr : IfAddr;
            MemWriteData  <= pickD ? DWData : MemWriteData;
            latWrite      <= pickD & DWrite;
            MemWriteFlag  <= pickD & DWrite;
            MemKernelFlag <= KernelMode;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          state <= IDLE;
          // Memory answers one cycle after the address, so capture happens here.
          if (winD) begin
            DValid      <= 1'b1;
            DRData      <= MemReadData;
            DFault      <= MemAccInv;
            MemInputRst <= ~latWrite & (MemAddr == IN_ADDR) & MemInputRecv & ~MemAccInv;
          end else begin
            IfValid <= 1'b1;
            IfData  <= MemReadData;
            IfFault <= MemAccInv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
